// File: rtl/hsfir_pkg.sv
// hsfir_pkg: shared types and helpers for the hsFIRcheap sequencer family.
// State encodings, ceil-log2 and saturation limits for a given sample width.
package hsfir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/hsfir_seq_if.sv
// hsfir_seq_if: sample stream, output stream and datapath control bundle.
// slave = sequencer side, master = source/sink/datapath side.
interface hsfir_seq_if
  import hsfir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NTAPS = 8,
  parameter int ACCW  = 20
);
  localparam int AW = clog2(NTAPS);

  logic                   i_valid;
  logic                   o_ready;
  logic signed [DW-1:0]   i_data;
  logic                   o_dp_we;
  logic [AW-1:0]          o_dp_wr_addr;
  logic signed [DW-1:0]   o_dp_wr_data;
  logic [AW-1:0]          o_dp_rd_addr;
  logic [AW-1:0]          o_dp_coef_idx;
  logic                   o_dp_acc_clr;
  logic                   o_dp_acc_en;
  logic signed [ACCW-1:0] i_dp_acc;
  logic                   o_valid;
  logic signed [DW-1:0]   o_data;
  logic                   i_ready;
  logic                   o_busy;

  modport slave (
    input  i_valid, i_data, i_dp_acc, i_ready,
    output o_ready, o_dp_we, o_dp_wr_addr,
    output o_dp_wr_data, o_dp_rd_addr,
    output o_dp_coef_idx, o_dp_acc_clr,
    output o_dp_acc_en, o_valid, o_data, o_busy
  );

  modport master (
    output i_valid, i_data, i_dp_acc, i_ready,
    input  o_ready, o_dp_we, o_dp_wr_addr,
    input  o_dp_wr_data, o_dp_rd_addr,
    input  o_dp_coef_idx, o_dp_acc_clr,
    input  o_dp_acc_en, o_valid, o_data, o_busy
  );

endinterface

// File: rtl/hsfir_sat.sv
// hsfir_sat: arithmetic right shift then clamp ACCW-bit value to DW bits.
// Purely combinational so other FIR variants can drop it in anywhere.
module hsfir_sat
  import hsfir_pkg::*;
#(
  parameter int ACCW  = 20,
  parameter int DW    = 8,
  parameter int SHIFT = 7
) (
  input  logic signed [ACCW-1:0] acc,
  output logic signed [DW-1:0]   y
);
  localparam logic signed [ACCW-1:0] HI = ACCW'(sat_hi(DW));
  localparam logic signed [ACCW-1:0] LO = ACCW'(sat_lo(DW));

  logic signed [ACCW-1:0] sh;

  assign sh = acc >>> SHIFT;

  // Clamp to the signed DW range, otherwise keep the low bits.
  always_comb begin
    y = sh[DW-1:0];
    if (sh > HI)      y = HI[DW-1:0];
    else if (sh < LO) y = LO[DW-1:0];
  end

endmodule

// File: rtl/hsfir_seq.sv
// hsfir_seq: single-MAC half-band FIR sequencer.
// Accept sample, run NTAPS MAC steps, drain pipeline, present result.
module hsfir_seq
  import hsfir_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NTAPS  = 8,
  parameter int ACCW   = 20,
  parameter int SHIFT  = 7,
  parameter int DP_LAT = 2
) (
  input logic        i_clk,
  input logic        i_reset,
  hsfir_seq_if.slave bus
);
  localparam int AW = clog2(NTAPS);
  localparam int LW = clog2(DP_LAT + 1);
  localparam logic [AW-1:0] LAST_K = AW'(NTAPS - 1);
  localparam logic [AW-1:0] NT     = AW'(NTAPS);
  localparam logic [LW-1:0] LAST_D = LW'(DP_LAT - 1);

  state_t               state;
  logic [AW-1:0]        head;
  logic [AW-1:0]        newest;
  logic [AW-1:0]        k;
  logic [LW-1:0]        d;
  logic                 accept;
  logic                 mac;
  logic [AW-1:0]        rd;
  logic signed [DW-1:0] sat_q;

  assign mac    = (state == MAC);
  assign accept = bus.i_valid && bus.o_ready;

  assign bus.o_ready      = (state == IDLE) && !i_reset;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_dp_we      = accept;
  assign bus.o_dp_wr_addr = head;
  assign bus.o_dp_wr_data = bus.i_data;

  // Tap k reads the sample k positions older than newest, wrapping.
  assign rd = (k > newest) ? NT - (k - newest)
                           : newest - k;

  assign bus.o_dp_acc_en   = mac;
  assign bus.o_dp_acc_clr  = mac && (k == '0);
  assign bus.o_dp_coef_idx = mac ? k : '0;
  assign bus.o_dp_rd_addr  = mac ? rd : '0;

  hsfir_sat #(
    .ACCW (ACCW),
    .DW   (DW),
    .SHIFT(SHIFT)
  ) u_sat (
    .acc(bus.i_dp_acc),
    .y  (sat_q)
  );

  // Control FSM: pointers, tap/drain counters and registered output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      head        <= '0;
      newest      <= '0;
      k           <= '0;
      d           <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            newest <= head;
            head   <= (head == LAST_K) ? '0 : head + AW'(1);
            k      <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          if (k == LAST_K) begin
            d     <= '0;
            state <= DRAIN;
          end else begin
            k <= k + AW'(1);
          end
        end
        DRAIN: begin
          if (d == LAST_D) begin
            bus.o_data  <= sat_q;
            bus.o_valid <= 1'b1;
            state       <= OUT;
          end else begin
            d <= d + LW'(1);
          end
        end
        OUT: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsfir_seq.sv
// tb_hsfir_seq: directed bench for the hsfir_seq sequencer.
// Models a DP_LAT=2 unity-coefficient datapath around the DUT.
module tb_hsfir_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hsfir_seq_if bus ();

  hsfir_seq dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int passed = 0;
  int total  = 0;

  logic        force_en;
  logic [19:0] force_val;

  logic [7:0]  mem [8];
  logic [19:0] racc;
  logic [19:0] dp_q;
  logic [7:0]  rdv;

  assign rdv          = mem[bus.o_dp_rd_addr];
  assign bus.i_dp_acc = force_en ? force_val : dp_q;

  // Datapath model: delay line, accumulator, one output register.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      racc <= '0;
      dp_q <= '0;
    end else begin
      if (bus.o_dp_we) mem[bus.o_dp_wr_addr] <= bus.o_dp_wr_data;
      if (bus.o_dp_acc_en)
        racc <= bus.o_dp_acc_clr ? {{12{rdv[7]}}, rdv}
                                 : racc + {{12{rdv[7]}}, rdv};
      dp_q <= racc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic feed(input logic [7:0] din, input logic [2:0] wa);
    logic [2:0] ra;
    bus.i_valid = 1'b1;
    bus.i_data  = din;
    @(negedge clk);
    total++;
    if (bus.o_dp_we !== 1'b1 || bus.o_dp_wr_addr !== wa ||
        bus.o_dp_wr_data !== din)
      $display("FAIL accept: we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
               bus.o_dp_we, bus.o_dp_wr_addr, bus.o_dp_wr_data, wa, din);
    else passed++;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ra = wa - 3'(k);
      @(negedge clk);
      total++;
      if (bus.o_dp_acc_en !== 1'b1 || bus.o_dp_acc_clr !== (k == 0) ||
          bus.o_dp_coef_idx !== 3'(k) || bus.o_dp_rd_addr !== ra)
        $display("FAIL mac k=%0d: en=%b clr=%b coef=%0d rd=%0d, want rd=%0d",
                 k, bus.o_dp_acc_en, bus.o_dp_acc_clr,
                 bus.o_dp_coef_idx, bus.o_dp_rd_addr, ra);
      else passed++;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      total++;
      if (bus.o_dp_acc_en !== 1'b0 || bus.o_valid !== 1'b0 ||
          bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0)
        $display("FAIL drain d=%0d: en=%b valid=%b busy=%b ready=%b",
                 d, bus.o_dp_acc_en, bus.o_valid, bus.o_busy, bus.o_ready);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic take_out(input logic [7:0] exp, input string nm);
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== exp)
      $display("FAIL out %s: valid=%b data=%h, want valid=1 data=%h",
               nm, bus.o_valid, bus.o_data, exp);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0)
      $display("FAIL idle %s: valid=%b ready=%b busy=%b, want 0 1 0",
               nm, bus.o_valid, bus.o_ready, bus.o_busy);
    else passed++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h11;
    bus.i_ready = 1'b1;
    force_en    = 1'b0;
    force_val   = '0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0 ||
          bus.o_data !== 8'h00 || bus.o_dp_we !== 1'b0 ||
          bus.o_busy !== 1'b0 || bus.o_dp_acc_en !== 1'b0)
        $display("FAIL reset: ready=%b valid=%b data=%h we=%b busy=%b en=%b",
                 bus.o_ready, bus.o_valid, bus.o_data,
                 bus.o_dp_we, bus.o_busy, bus.o_dp_acc_en);
      else passed++;
    end
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_ready !== 1'b1)
      $display("FAIL reset release: ready=%b, want 1", bus.o_ready);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    feed(8'h40, 3'd0);
    take_out(8'h00, "impulse");
  endtask

  task automatic test_wrap();
    logic [7:0] exp [10];
    exp = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4};
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      feed(8'h40, 3'(i % 8));
      take_out(exp[i], $sformatf("wrap%0d", i));
    end
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    feed(8'h40, 3'd2);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h55;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h04 ||
          bus.o_ready !== 1'b0 || bus.o_dp_we !== 1'b0)
        $display("FAIL hold: valid=%b data=%h ready=%b we=%b, want 1 04 0 0",
                 bus.o_valid, bus.o_data, bus.o_ready, bus.o_dp_we);
      else passed++;
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_dp_we !== 1'b0 || bus.o_ready !== 1'b0)
      $display("FAIL handshake: valid=%b we=%b ready=%b, want 1 0 0",
               bus.o_valid, bus.o_dp_we, bus.o_ready);
    else passed++;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0)
      $display("FAIL after handshake: valid=%b ready=%b busy=%b, want 0 1 0",
               bus.o_valid, bus.o_ready, bus.o_busy);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [19:0] acc [3];
    logic [7:0]  exp [3];
    acc = '{20'h7FFFF, 20'h80000, 20'h00380};
    exp = '{8'h7F, 8'h80, 8'h07};
    force_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      force_val = acc[i];
      feed(8'h01, 3'(3 + i));
      take_out(exp[i], $sformatf("sat%0d", i));
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h22;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus.o_dp_coef_idx !== 3'd3 || bus.o_dp_acc_en !== 1'b1)
      $display("FAIL mid k: coef=%0d en=%b, want 3 1",
               bus.o_dp_coef_idx, bus.o_dp_acc_en);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_dp_acc_en !== 1'b0 ||
        bus.o_dp_acc_clr !== 1'b0 || bus.o_dp_we !== 1'b0 ||
        bus.o_valid !== 1'b0)
      $display("FAIL mid reset: busy=%b en=%b clr=%b we=%b valid=%b",
               bus.o_busy, bus.o_dp_acc_en, bus.o_dp_acc_clr,
               bus.o_dp_we, bus.o_valid);
    else passed++;
    rst = 1'b0;
    feed(8'h30, 3'd0);
    take_out(8'h00, "post reset");
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_wrap();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
